// File: rtl/int_event_fifo_sequencer_pkg.sv
// Shared definitions for the interrupt-event FIFO sequencer.
// Holds the width helper used for source-id sizing and the read-side FSM encodings.
// No logic lives here; every sequencer file imports this package.
package int_event_fifo_sequencer_pkg;

   // Ceiling log2 for constant width sizing (value >= 2 in practice).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Read-side sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_CAPT = 2'd2,
      ST_HOLD = 2'd3
   } rd_state_t;

endpackage

// File: rtl/int_event_fifo_sequencer_rr.sv
// Round-robin arbiter for the event write side, with its own rotating pointer.
// Latency: grant is combinational (zero cycles); pointer moves on the clock after a grant.
// Backpressure: i_en low suppresses every grant and freezes the pointer.
// Ports: clock/resetn; i_req request vector; i_en grant enable;
//        o_grant one-hot grant; o_winner encoded winner; o_any any grant issued.
module int_event_rr_arbiter
   import int_event_fifo_sequencer_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   localparam int SRC_WIDTH = clog2(NUM_REQ)
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic                 i_en,
   output logic [NUM_REQ-1:0]   o_grant,
   output logic [SRC_WIDTH-1:0] o_winner,
   output logic                 o_any
);

   localparam int SW1 = SRC_WIDTH + 1;

   logic [SRC_WIDTH-1:0] r_rr_ptr;
   logic [SW1-1:0]       w_sum;
   logic [SRC_WIDTH-1:0] w_idx;
   logic                 w_found;

   // Scan starting at the pointer; the extra sum bit lets the wrap work for
   // requester counts that are not a power of two.
   always_comb begin
      w_sum    = '0;
      w_idx    = '0;
      w_found  = 1'b0;
      o_winner = '0;
      o_grant  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + SW1'(k);
         if (w_sum >= SW1'(NUM_REQ)) begin
            w_sum = w_sum - SW1'(NUM_REQ);
         end
         w_idx = w_sum[SRC_WIDTH-1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found  = 1'b1;
            o_winner = w_idx;
         end
      end
      o_any = w_found & i_en;
      if (o_any) begin
         o_grant[o_winner] = 1'b1;
      end
   end

   // Next search starts just past the last winner.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_rr_ptr <= '0;
      end else if (o_any) begin
         if (o_winner == SRC_WIDTH'(NUM_REQ - 1)) begin
            r_rr_ptr <= '0;
         end else begin
            r_rr_ptr <= o_winner + 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_event_fifo_sequencer.sv
// Interrupt-event FIFO sequencer: arbitrates event writers into the FIFO and pops entries into a held irq.
// Latency: write accept is combinational; a pop shows on irq two cycles after fifoRdEn.
// Backpressure: fifoFull blocks all writes; a pending irq blocks further pops until irqAck.
// Ports: clock/resetn; reqValid/reqData/reqReady event sources; fifoWrEn/fifoWrData/fifoFull write side;
//        fifoRdEn/fifoRdData/fifoEmpty read side; irq/irqSrc/irqData/irqAck interrupt presentation.
module int_event_fifo_sequencer
   import int_event_fifo_sequencer_pkg::*;
#(
   parameter int  NUM_REQ    = 4,
   parameter int  EVT_WIDTH  = 8,
   localparam int SRC_WIDTH  = clog2(NUM_REQ),
   localparam int FIFO_WIDTH = SRC_WIDTH + EVT_WIDTH
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           reqValid,
   input  logic [NUM_REQ*EVT_WIDTH-1:0] reqData,
   output logic [NUM_REQ-1:0]           reqReady,
   output logic                         fifoWrEn,
   output logic [FIFO_WIDTH-1:0]        fifoWrData,
   input  logic                         fifoFull,
   output logic                         fifoRdEn,
   input  logic [FIFO_WIDTH-1:0]        fifoRdData,
   input  logic                         fifoEmpty,
   output logic                         irq,
   output logic [SRC_WIDTH-1:0]         irqSrc,
   output logic [EVT_WIDTH-1:0]         irqData,
   input  logic                         irqAck
);

   // ---------------- write side ----------------
   logic                 w_wr_en;
   logic [NUM_REQ-1:0]   w_grant;
   logic [SRC_WIDTH-1:0] w_winner;
   logic                 w_any;
   logic [EVT_WIDTH-1:0] w_payload;

   // Full is treated conservatively: a pop in the same cycle does not free a slot.
   // Reset also blocks grants so nothing is accepted while the FIFO is clearing.
   assign w_wr_en = resetn & ~fifoFull;

   int_event_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clock    (clock),
      .resetn   (resetn),
      .i_req    (reqValid),
      .i_en     (w_wr_en),
      .o_grant  (w_grant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   always_comb begin
      w_payload = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == SRC_WIDTH'(i)) begin
            w_payload = reqData[i*EVT_WIDTH +: EVT_WIDTH];
         end
      end
   end

   assign reqReady   = w_grant;
   assign fifoWrEn   = w_any;
   assign fifoWrData = {w_winner, w_payload};

   // ---------------- read side ----------------
   rd_state_t            r_state;
   rd_state_t            w_state_nxt;
   logic                 w_rd_en;
   logic                 w_capt;
   logic                 w_clr;
   logic                 r_irq;
   logic [SRC_WIDTH-1:0] r_irq_src;
   logic [EVT_WIDTH-1:0] r_irq_data;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_capt      = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!fifoEmpty && !r_irq) begin
               w_state_nxt = ST_POP;
            end
         end
         ST_POP: begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_CAPT;
         end
         ST_CAPT: begin
            // Synchronous-read data is valid now, one cycle after the strobe.
            w_capt      = 1'b1;
            w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (irqAck) begin
               w_clr       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_irq      <= 1'b0;
         r_irq_src  <= '0;
         r_irq_data <= '0;
      end else if (w_capt) begin
         r_irq      <= 1'b1;
         r_irq_src  <= fifoRdData[FIFO_WIDTH-1 -: SRC_WIDTH];
         r_irq_data <= fifoRdData[EVT_WIDTH-1:0];
      end else if (w_clr) begin
         r_irq      <= 1'b0;
      end
   end

   assign fifoRdEn = w_rd_en;
   assign irq      = r_irq;
   assign irqSrc   = r_irq_src;
   assign irqData  = r_irq_data;

endmodule

// File: tb/tb_int_event_fifo_sequencer.sv
// Bench for the interrupt-event FIFO sequencer with an attached FIFO model and scoreboard.
module tb_int_event_fifo_sequencer;

   localparam int N     = 4;
   localparam int EW    = 8;
   localparam int SW    = 2;
   localparam int FW    = SW + EW;
   localparam int DEPTH = 8;

   logic            clock = 1'b0;
   logic            resetn;
   logic [N-1:0]    reqValid;
   logic [N*EW-1:0] reqData;
   logic [N-1:0]    reqReady;
   logic            fifoWrEn;
   logic [FW-1:0]   fifoWrData;
   logic            fifoFull;
   logic            fifoRdEn;
   logic [FW-1:0]   fifoRdData;
   logic            fifoEmpty;
   logic            irq;
   logic [SW-1:0]   irqSrc;
   logic [EW-1:0]   irqData;
   logic            irqAck;

   always #5 clock = ~clock;

   int_event_fifo_sequencer #(.NUM_REQ(N), .EVT_WIDTH(EW)) u_dut (
      .clock      (clock),
      .resetn     (resetn),
      .reqValid   (reqValid),
      .reqData    (reqData),
      .reqReady   (reqReady),
      .fifoWrEn   (fifoWrEn),
      .fifoWrData (fifoWrData),
      .fifoFull   (fifoFull),
      .fifoRdEn   (fifoRdEn),
      .fifoRdData (fifoRdData),
      .fifoEmpty  (fifoEmpty),
      .irq        (irq),
      .irqSrc     (irqSrc),
      .irqData    (irqData),
      .irqAck     (irqAck)
   );

   // Synchronous-read FIFO attached to the DUT, sharing its reset.
   logic [FW-1:0] mem [0:DEPTH-1];
   logic [2:0]    wp, rp;
   logic [3:0]    cnt;
   logic [FW-1:0] rd_q;
   logic          tb_full;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wp   <= 3'd0;
         rp   <= 3'd0;
         cnt  <= 4'd0;
         rd_q <= '0;
      end else begin
         if (fifoWrEn) begin
            mem[wp] <= fifoWrData;
            wp      <= wp + 3'd1;
         end
         if (fifoRdEn) begin
            rd_q <= mem[rp];
            rp   <= rp + 3'd1;
         end
         cnt <= cnt + {3'd0, fifoWrEn} - {3'd0, fifoRdEn};
      end
   end

   assign fifoFull   = tb_full | (cnt == 4'd8);
   assign fifoEmpty  = (cnt == 4'd0);
   assign fifoRdData = rd_q;

   // Reference state: rotating priority start and expected FIFO word order.
   int            checks = 0;
   int            errors = 0;
   int            m_ptr = 0;
   int            rd_pulses = 0;
   int            irq_rises = 0;
   logic          prev_irq = 1'b0;
   logic          prev_rd = 1'b0;
   logic [FW-1:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after the negedge on which inputs were driven.
   task automatic step_begin();
      logic [N-1:0]  e_rdy;
      logic          e_en;
      logic [FW-1:0] e_dat;
      int            w;
      #1;
      e_rdy = '0;
      e_en  = 1'b0;
      e_dat = '0;
      w     = -1;
      if (!resetn) begin
         m_ptr = 0;
         exp_q.delete();
      end else if (!fifoFull) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && reqValid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
      end
      if (w >= 0) begin
         e_rdy[w] = 1'b1;
         e_en     = 1'b1;
         e_dat    = {w[SW-1:0], reqData[w*EW +: EW]};
      end
      chk("reqReady", 32'(reqReady), 32'(e_rdy));
      chk("fifoWrEn", 32'(fifoWrEn), 32'(e_en));
      if (e_en) begin
         chk("fifoWrData", 32'(fifoWrData), 32'(e_dat));
         exp_q.push_back(e_dat);
         m_ptr = (w + 1) % N;
      end
      if (fifoRdEn) begin
         rd_pulses++;
         chk("rd_while_irq", 32'(irq), 32'(0));
         chk("rd_while_empty", 32'(fifoEmpty), 32'(0));
         chk("rd_pulse_width", 32'(prev_rd), 32'(0));
      end
      if (irq && !prev_irq) begin
         irq_rises++;
         chk("irq_has_entry", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) chk("irq_word", 32'({irqSrc, irqData}), 32'(exp_q.pop_front()));
      end
      prev_irq = irq;
      prev_rd  = fifoRdEn;
   endtask

   task automatic step_end();
      @(negedge clock);
   endtask

   // Leaves the bench mid-cycle in the POP cycle when found.
   task automatic wait_rd(input int budget, output bit found);
      found = 1'b0;
      for (int n = 0; n < budget && !found; n++) begin
         step_begin();
         if (fifoRdEn) found = 1'b1;
         else step_end();
      end
      chk("wait_rd", 32'(found), 32'(1));
   endtask

   task automatic drain(input int budget);
      int idle;
      int n;
      idle     = 0;
      n        = 0;
      reqValid = '0;
      tb_full  = 1'b0;
      while (idle < 4 && n < budget) begin
         irqAck = irq;
         step_begin();
         if (fifoEmpty && !irq && !fifoRdEn) idle++;
         else idle = 0;
         step_end();
         n++;
      end
      irqAck = 1'b0;
      chk("drain_done", 32'(idle >= 4), 32'(1));
      chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int            order [5];
      logic [FW-1:0] tmp;
      logic [EW-1:0] pay;
      logic [N-1:0]  held;
      logic [N-1:0]  nb;
      bit            found;
      int            base_rd;
      int            base_irq;
      int            hcnt;

      order = '{0, 1, 2, 3, 0};

      // Reset with every requester asserting.
      resetn   = 1'b0;
      reqValid = '1;
      reqData  = $urandom;
      tb_full  = 1'b0;
      irqAck   = 1'b0;
      @(negedge clock);
      step_begin();
      chk("rst_irq", 32'(irq), 32'(0));
      chk("rst_irqSrc", 32'(irqSrc), 32'(0));
      chk("rst_irqData", 32'(irqData), 32'(0));
      chk("rst_fifoRdEn", 32'(fifoRdEn), 32'(0));
      step_end();

      // Round-robin order after release.
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         reqData = $urandom;
         step_begin();
         tmp = fifoWrData;
         chk("rr_order", 32'(tmp[FW-1 -: SW]), 32'(order[i]));
         step_end();
      end
      drain(200);

      // Full blocks everything; release writes req2 in the same cycle.
      tb_full  = 1'b1;
      reqValid = 4'b0100;
      pay      = EW'($urandom);
      reqData  = '0;
      reqData[2*EW +: EW] = pay;
      for (int i = 0; i < 4; i++) begin
         step_begin();
         chk("full_ready", 32'(reqReady), 32'(0));
         chk("full_wren", 32'(fifoWrEn), 32'(0));
         step_end();
      end
      tb_full = 1'b0;
      step_begin();
      chk("unfull_wren", 32'(fifoWrEn), 32'(1));
      chk("unfull_data", 32'(fifoWrData), 32'({2'd2, pay}));
      step_end();
      reqValid = 4'b1111;
      step_begin();
      chk("ptr_after_full", 32'(reqReady), 32'(4'b1000));
      step_end();
      drain(200);

      // Single entry {1, A5}: pop, capture, hold, ack.
      reqValid = 4'b0010;
      reqData  = '0;
      reqData[1*EW +: EW] = 8'hA5;
      step_begin();
      step_end();
      reqValid = '0;
      wait_rd(10, found);
      step_end();
      step_begin();
      chk("capt_rden", 32'(fifoRdEn), 32'(0));
      chk("capt_irq", 32'(irq), 32'(0));
      step_end();
      for (int i = 0; i < 4; i++) begin
         step_begin();
         chk("hold_irq", 32'(irq), 32'(1));
         chk("hold_src", 32'(irqSrc), 32'(1));
         chk("hold_data", 32'(irqData), 32'(8'hA5));
         step_end();
      end
      irqAck = 1'b1;
      step_begin();
      step_end();
      irqAck = 1'b0;
      step_begin();
      chk("ack_clears_irq", 32'(irq), 32'(0));
      step_end();
      drain(50);

      // Three queued entries, ack five cycles after each rise.
      base_rd  = rd_pulses;
      base_irq = irq_rises;
      reqValid = 4'b0001; reqData = $urandom; step_begin(); step_end();
      reqValid = 4'b0100; reqData = $urandom; step_begin(); step_end();
      reqValid = 4'b1000; reqData = $urandom; step_begin(); step_end();
      reqValid = '0;
      hcnt = 0;
      for (int i = 0; i < 50; i++) begin
         if (irq) hcnt++;
         else hcnt = 0;
         irqAck = (hcnt == 5);
         step_begin();
         step_end();
      end
      irqAck = 1'b0;
      chk("three_pops", 32'(rd_pulses - base_rd), 32'(3));
      chk("three_irqs", 32'(irq_rises - base_irq), 32'(3));
      chk("three_sb_empty", 32'(exp_q.size()), 32'(0));

      // Ack in IDLE is ignored.
      irqAck = 1'b1;
      step_begin();
      step_end();
      irqAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_begin();
         chk("idle_ack_irq", 32'(irq), 32'(0));
         chk("idle_ack_rden", 32'(fifoRdEn), 32'(0));
         step_end();
      end

      // Ack in POP is ignored: irq still rises.
      reqValid = 4'b0001;
      reqData  = $urandom;
      step_begin();
      step_end();
      reqValid = '0;
      wait_rd(10, found);
      irqAck = 1'b1;
      step_end();
      irqAck = 1'b0;
      step_begin();
      chk("pop_ack_capt_irq", 32'(irq), 32'(0));
      step_end();
      step_begin();
      chk("pop_ack_hold_irq", 32'(irq), 32'(1));
      step_end();
      drain(50);

      // Reset while an entry is in CAPT.
      reqValid = 4'b0100;
      reqData  = $urandom;
      step_begin();
      step_end();
      reqValid = '0;
      wait_rd(10, found);
      step_end();
      resetn = 1'b0;
      step_begin();
      chk("rst_capt_irq", 32'(irq), 32'(0));
      chk("rst_capt_rden", 32'(fifoRdEn), 32'(0));
      step_end();
      step_begin();
      chk("rst_hold_irq", 32'(irq), 32'(0));
      step_end();
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step_begin();
         chk("post_rst_rden", 32'(fifoRdEn), 32'(0));
         chk("post_rst_empty", 32'(fifoEmpty), 32'(1));
         chk("post_rst_irq", 32'(irq), 32'(0));
         step_end();
      end

      // Randomized traffic with held-until-accepted requests.
      held = '0;
      for (int r = 0; r < 400; r++) begin
         nb = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            if (!held[i]) reqData[i*EW +: EW] = EW'($urandom);
         end
         reqValid = held | nb;
         tb_full  = ($urandom_range(0, 7) == 0);
         irqAck   = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         step_begin();
         held = reqValid & ~reqReady;
         step_end();
      end
      irqAck = 1'b0;
      drain(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
